// File: rtl/or_sticky_n.sv
// or_sticky_n: N-input sticky OR aggregator with a four-phase req/ack port.
// Each input event sets a pending bit that holds until it is captured into
// the snapshot vector handed to the consumer. Events on a bit that is
// already pending are counted as lost and reported through ovf.
//
// Build option:
//   OR_STICKY_EDGE_EN  defined     -> rising edges of x are events
//                      not defined -> every cycle with x[i]=1 is an event
module or_sticky_n #(
    parameter int unsigned N = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [N-1:0] x,
    input  logic [N-1:0] mask,
    output logic         req,
    input  logic         ack,
    output logic [N-1:0] vec,
    output logic         ovf,
    output logic         any
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] WAITLOW = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [N-1:0] pending;
    logic [N-1:0] pending_next;
    logic [N-1:0] ev;
    logic [N-1:0] hit;
    logic [N-1:0] clr;
    logic         lost;
    logic         lost_next;
    logic         take;

`ifdef OR_STICKY_EDGE_EN
    logic [N-1:0] x_q;

    // Previous input sample for rising-edge detection.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            x_q <= '0;
        end else begin
            x_q <= x;
        end
    end

    // Only a 0->1 transition is an event; a held level counts once.
    always_comb begin
        ev = x & ~x_q;
    end
`else
    // Level mode: every cycle with the input high is an event.
    always_comb begin
        ev = x;
    end
`endif

    // Capture decision and next-state values for pending/lost/FSM.
    always_comb begin
        hit          = pending & mask;
        take         = (state == IDLE) && (hit != '0);
        clr          = take ? hit : '0;
        // A new event on a bit being cleared this cycle stays pending.
        pending_next = (pending & ~clr) | ev;
        lost_next    = (lost & ~take) | (|(ev & pending));
        state_next   = state;
        case (state)
            IDLE:    if (take) state_next = REQ;
            REQ:     if (ack)  state_next = WAITLOW;
            WAITLOW: if (!ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sticky event bookkeeping and the registered status output.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            pending <= '0;
            lost    <= 1'b0;
            any     <= 1'b0;
        end else begin
            pending <= pending_next;
            lost    <= lost_next;
            any     <= |(pending_next & mask);
        end
    end

    // Handshake FSM; vec/ovf only change at the capture edge in IDLE.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            req   <= 1'b0;
            vec   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (take) begin
                vec <= hit;
                ovf <= lost;
                req <= 1'b1;
            end else if (state == REQ && ack) begin
                req <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // The snapshot must not move while the consumer may be sampling it.
    a_snapshot_stable: assert property (
        @(posedge clock) disable iff (!reset_)
        req |=> (!req || ($stable(vec) && $stable(ovf))));

    // req is high exactly in the REQ state.
    a_req_state: assert property (
        @(posedge clock) disable iff (!reset_)
        req == (state == REQ));

    // The FSM never reaches the unused encoding.
    a_state_legal: assert property (
        @(posedge clock) disable iff (!reset_)
        state != 2'd3);
`endif

endmodule

// File: tb/tb_or_sticky_n.sv
// Self-checking bench for or_sticky_n. Expected snapshots {ovf, vec} are
// queued as stimulus is driven and popped as each request is observed.
module tb_or_sticky_n;

    localparam int unsigned N = 8;

    logic         clock = 1'b0;
    logic         reset_;
    logic [N-1:0] x;
    logic [N-1:0] mask;
    logic         req;
    logic         ack;
    logic [N-1:0] vec;
    logic         ovf;
    logic         any;

    int compared   = 0;
    int mismatched = 0;
    logic [N:0] exp_q[$];

    or_sticky_n #(.N(N)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .x      (x),
        .mask   (mask),
        .req    (req),
        .ack    (ack),
        .vec    (vec),
        .ovf    (ovf),
        .any    (any)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Wait up to budget edges for req to be high.
    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Raise ack until req drops, then lower it and let the FSM return to IDLE.
    task automatic release_hs(output bit ok);
        ok  = 1'b0;
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        ack = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset_ = 1'b1;
        x      = '0;
        mask   = '0;
        ack    = 1'b0;
        #2 reset_ = 1'b0;
        #1;
        compared++;
        if ({req, ovf, any, vec} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: req=%b ovf=%b any=%b vec=%h, expected all 0", req, ovf, any, vec);
        end
        repeat (3) @(posedge clock);
        #3 reset_ = 1'b1;
        tick();
        compared++;
        if ({req, ovf, any, vec} !== '0) begin
            mismatched++;
            $display("FAIL post_reset_idle: req=%b ovf=%b any=%b vec=%h, expected all 0", req, ovf, any, vec);
        end
    endtask

    task automatic test_basic;
        bit ok;
        logic [N:0] e;
        exp_q.push_back({1'b0, 8'h05});
        mask = 8'hFF;
        x    = 8'h05;
        tick();
        x = '0;
        compared++;
        if (any !== 1'b1 || req !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_pending: any=%b req=%b, expected any=1 req=0", any, req);
        end
        wait_req(1, ok);
        e = exp_q.pop_front();
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL basic_latency: req=%b one edge after sample, expected 1", req);
        end else begin
            compared++;
            if ({ovf, vec} !== e) begin
                mismatched++;
                $display("FAIL basic_snap: vec=%h ovf=%b, expected vec=%h ovf=%b", vec, ovf, e[N-1:0], e[N]);
            end
        end
        ack = 1'b1;
        tick();
        compared++;
        if (req !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_ack_drop: req=%b, expected 0", req);
        end
        ack = 1'b0;
        tick();
        compared++;
        if (any !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_cleared: any=%b, expected 0", any);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (req !== 1'b0) begin
                mismatched++;
                $display("FAIL basic_quiet: req=%b in idle cycle %0d, expected 0", req, i);
            end
        end
    endtask

    task automatic test_mask;
        bit ok;
        logic [N:0] e;
        mask = 8'h0F;
        x    = 8'h30;
        tick();
        x = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (req !== 1'b0 || any !== 1'b0) begin
                mismatched++;
                $display("FAIL mask_hidden: req=%b any=%b cycle %0d, expected 0 0", req, any, i);
            end
        end
        exp_q.push_back({1'b0, 8'h30});
        mask = 8'hFF;
        wait_req(1, ok);
        e = exp_q.pop_front();
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL mask_unmask_req: req=%b, expected 1 one edge after unmask", req);
        end else begin
            compared++;
            if ({ovf, vec} !== e) begin
                mismatched++;
                $display("FAIL mask_snap: vec=%h ovf=%b, expected vec=%h ovf=%b", vec, ovf, e[N-1:0], e[N]);
            end
        end
        release_hs(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL mask_release: req=%b, expected 0 after ack", req);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [N:0] e;
        exp_q.push_back({1'b0, 8'h01});
        x = 8'h01;
        tick();
        x = '0;
        wait_req(1, ok);
        e = exp_q.pop_front();
        compared++;
        if (!ok || {ovf, vec} !== e) begin
            mismatched++;
            $display("FAIL b2b_first: req=%b vec=%h ovf=%b, expected req=1 vec=%h ovf=%b", req, vec, ovf, e[N-1:0], e[N]);
        end
        // Two separate events on bit 2 while the first snapshot is in flight.
        x = 8'h04; tick();
        x = '0;    tick();
        x = 8'h04; tick();
        x = '0;    tick();
        compared++;
        if (req !== 1'b1 || vec !== 8'h01 || ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_hold: req=%b vec=%h ovf=%b, expected req=1 vec=01 ovf=0", req, vec, ovf);
        end
        ack = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (req !== 1'b0) begin
                mismatched++;
                $display("FAIL b2b_waitlow: req=%b while ack held, expected 0", req);
            end
        end
        ack = 1'b0;
        tick();
        exp_q.push_back({1'b1, 8'h04});
        wait_req(1, ok);
        e = exp_q.pop_front();
        compared++;
        if (!ok || {ovf, vec} !== e) begin
            mismatched++;
            $display("FAIL b2b_second: req=%b vec=%h ovf=%b, expected req=1 vec=%h ovf=%b", req, vec, ovf, e[N-1:0], e[N]);
        end
        release_hs(ok);
        exp_q.push_back({1'b0, 8'h04});
        x = 8'h04;
        tick();
        x = '0;
        wait_req(1, ok);
        e = exp_q.pop_front();
        compared++;
        if (!ok || {ovf, vec} !== e) begin
            mismatched++;
            $display("FAIL b2b_third: req=%b vec=%h ovf=%b, expected req=1 vec=%h ovf=%b", req, vec, ovf, e[N-1:0], e[N]);
        end
        release_hs(ok);
        compared++;
        if (any !== 1'b0 || req !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_drained: any=%b req=%b, expected 0 0", any, req);
        end
    endtask

    task automatic test_same_cycle;
        bit ok;
        logic [N:0] e;
        // Park bit 1 pending behind the mask, then unmask it on the same
        // edge that a fresh bit-1 event arrives.
        mask = 8'hFD;
        x    = 8'h02;
        tick();
        x = '0;
        tick();
        compared++;
        if (req !== 1'b0 || any !== 1'b0) begin
            mismatched++;
            $display("FAIL same_masked: req=%b any=%b, expected 0 0", req, any);
        end
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b1, 8'h02});
        mask = 8'hFF;
        x    = 8'h02;
        wait_req(1, ok);
        x = '0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) wait_req(1, ok);
            e = exp_q.pop_front();
            compared++;
            if (!ok || {ovf, vec} !== e) begin
                mismatched++;
                $display("FAIL same_snap%0d: req=%b vec=%h ovf=%b, expected req=1 vec=%h ovf=%b", k, req, vec, ovf, e[N-1:0], e[N]);
            end
            release_hs(ok);
        end
        tick();
        compared++;
        if (req !== 1'b0) begin
            mismatched++;
            $display("FAIL same_quiet: req=%b, expected 0", req);
        end
    endtask

    task automatic test_held_level;
        bit ok;
        int nsnap;
        logic [N:0] e;
`ifdef OR_STICKY_EDGE_EN
        exp_q.push_back({1'b0, 8'h01});
`else
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'h01});
`endif
        nsnap = exp_q.size();
        x = 8'h01;
        repeat (10) tick();
        x = '0;
        for (int k = 0; k < nsnap; k++) begin
            if (k > 0) wait_req(1, ok);
            else       ok = (req === 1'b1);
            e = exp_q.pop_front();
            compared++;
            if (!ok || {ovf, vec} !== e) begin
                mismatched++;
                $display("FAIL held_snap%0d: req=%b vec=%h ovf=%b, expected req=1 vec=%h ovf=%b", k, req, vec, ovf, e[N-1:0], e[N]);
            end
            release_hs(ok);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            compared++;
            if (req !== 1'b0) begin
                mismatched++;
                $display("FAIL held_extra_req: req=%b cycle %0d, expected 0", req, i);
            end
        end
    endtask

    task automatic test_reset_in_req;
        bit ok;
        logic [N:0] e;
        exp_q.push_back({1'b0, 8'h08});
        x = 8'h08;
        tick();
        x = '0;
        wait_req(1, ok);
        e = exp_q.pop_front();
        compared++;
        if (!ok || {ovf, vec} !== e) begin
            mismatched++;
            $display("FAIL rst_snap: req=%b vec=%h ovf=%b, expected req=1 vec=%h ovf=%b", req, vec, ovf, e[N-1:0], e[N]);
        end
        x = 8'h10;
        tick();
        x = '0;
        compared++;
        if (any !== 1'b1 || req !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_before: any=%b req=%b, expected 1 1", any, req);
        end
        #2 reset_ = 1'b0;
        #1;
        compared++;
        if ({req, ovf, any, vec} !== '0) begin
            mismatched++;
            $display("FAIL rst_async: req=%b ovf=%b any=%b vec=%h, expected all 0", req, ovf, any, vec);
        end
        #4 reset_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            compared++;
            if (req !== 1'b0 || any !== 1'b0) begin
                mismatched++;
                $display("FAIL rst_after: req=%b any=%b cycle %0d, expected 0 0", req, any, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_back_to_back();
        test_same_cycle();
        test_held_level();
        test_reset_in_req();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/or_sticky_n.md
# or_sticky_n

Parametrised N-input sticky OR aggregator with a four-phase request/acknowledge output port. Each input event sets a pending bit that holds until it is handed off. The masked OR of the pending bits starts a handshake that delivers a snapshot vector to the consumer. It is the sequential successor of the two-input combinational OR: it sits between event sources and a consumer such as an interrupt controller or processor status port.

## Interface
- N, 8 — number of input channels (1..32).
- clock  input  1  — single clock, rising edge.
- reset_  input  1  — asynchronous reset, active low.
- x  input  N  — event inputs, sampled on rising edge of clock.
- mask  input  N  — 1 = channel enabled for the request condition and the snapshot.
- req  output  1  — request to the consumer, four-phase.
- ack  input  1  — acknowledge from the consumer.
- vec  output  N  — snapshot of masked pending bits; stable while req=1.
- ovf  output  1  — at least one event was lost since the previous snapshot; stable while req=1.
- any  output  1  — registered OR of (pending & mask); status only.

## Operation
- Internal regs: pending[N-1:0], lost (1 bit), state.
- Reset values: pending=0, lost=0, state=IDLE, req=0, vec=0, ovf=0, any=0.
- ev[i] is the event condition on channel i. See Configuration for its definition.
- Pending update each cycle: pending_next = (pending & ~clr) | ev. clr is the snapshot being taken this cycle, else 0.
  - A set on the same bit in the same cycle as a clear wins, so the new event stays pending.
- lost_next = (lost & ~take) | |(ev & pending). An event on an already-pending bit is lost.
  - A set wins over a clear.
- Masked-off pending bits stay pending. They are delivered once unmasked.
- FSM states:
  - IDLE: if (pending & mask) != 0, then take=1, vec<=pending&mask, ovf<=lost, clr=pending&mask, req<=1, go to REQ. Otherwise stay.
  - REQ: req=1, vec and ovf held. When ack=1: req<=0, go to WAITLOW.
  - WAITLOW: req=0. When ack=0, go to IDLE. vec and ovf keep their last value.
- ack=1 in IDLE is ignored. The block does not leave WAITLOW until ack returns to 0.
- any <= |(pending_next & mask) every cycle, independent of state.
- Asserting reset_ at any point forces all reset values immediately. Any handshake in flight is abandoned.

## Timing
- The event is sampled at edge t. The pending bit and any are visible after edge t.
- req rises after edge t+1 if the FSM was in IDLE. Minimum event-to-req latency is 2 edges.
- The consumer samples vec and ovf when it sees req=1.
- Minimum full handshake is 3 cycles: IDLE→REQ→WAITLOW→IDLE. The next req can rise 1 cycle after returning to IDLE.
- The mask is sampled only in IDLE at the capture edge. Mask changes during REQ/WAITLOW do not alter vec.
- Back-to-back events on one channel during REQ/WAITLOW:
  - First event: pending=1.
  - Second event: lost=1.
  - Both are reported together in the next snapshot.

## Configuration
- OR_STICKY_EDGE_EN defined:
  - An extra register x_q[N-1:0] (reset 0) holds the previous x.
  - ev = x & ~x_q, i.e. rising edges only. A level held high produces one event.
  - x already high at the first edge after reset counts as an edge.
- Not defined: ev = x, level mode. Each cycle x[i]=1 is an event.
  - A held level re-sets pending immediately after each snapshot.
  - While pending is already set, it also sets lost every cycle.

## Test plan
- Reset, then x=8'h05 for 1 cycle, mask=8'hFF → req rises 2 edges after the sample; vec=8'h05, ovf=0; ack high → req low; ack low → IDLE, pending=0.
- mask=8'h0F, x=8'h30 pulse → req stays 0, any=0. Then mask=8'hFF → req rises next cycle, vec=8'h30.
- While in REQ, pulse x[2] twice in separate cycles → next snapshot has vec[2]=1, ovf=1. The snapshot after that has ovf=0.
- Event on bit 1 in the same cycle as the capture that clears bit 1 → first vec[1]=1, then a second req with vec[1]=1.
- With OR_STICKY_EDGE_EN, x[0] held high for 10 cycles → exactly one req, ovf=0. Without the macro → repeated reqs, ovf=1 on the second snapshot.
- reset_ pulled low while in REQ → req, vec, ovf, any drop to 0 asynchronously. After release with x=0, there is no req.
